// File: rtl/risc24_exec_core.sv
// RISC24 multicycle execute core: ALU, Moore FSM control and data memory.
// Optional feature macro: RISC24_ILLEGAL_TRAP_EN (trap undefined encodings into HALT).
module risc24_exec_core #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] sw_data,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_zero,
  output logic              alu_carry,
  output logic              flag_c,
  output logic              flag_z,
  output logic [1:0]        alu_ctrl,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              pc_write,
  output logic              branch,
  output logic              jal,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] mem_out,
  output logic              illegal
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [3:0] OpAlu  = 4'b0000;
  localparam logic [3:0] OpNand = 4'b0010;
  localparam logic [3:0] OpLw   = 4'b1010;
  localparam logic [3:0] OpSw   = 4'b1001;
  localparam logic [3:0] OpBeq  = 4'b1011;
  localparam logic [3:0] OpJal  = 4'b1101;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluNand = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;
  localparam logic [1:0] AluPass = 2'b11;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc  = 2'b10;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [3:0] opcode;
  logic [1:0] funct;
  logic       is_add, is_adc, is_ndu, is_ndz, is_lw, is_sw, is_beq, is_jal;
  logic       is_alu_grp, is_legal, wb_write_en;

  logic [DATA_W-1:0] op_b, imm_sext;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] mem_addr;

  // Register-field bits are consumed by the external register file, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir_q[11:6];

  // ---------------------------------------------------------------------------
  // Decode from the latched instruction
  // ---------------------------------------------------------------------------
  assign opcode = ir_q[DATA_W-1 -: 4];
  assign funct  = ir_q[1:0];

  always_comb begin
    is_add     = (opcode == OpAlu)  && (funct == 2'b00);
    is_adc     = (opcode == OpAlu)  && (funct == 2'b10);
    is_ndu     = (opcode == OpNand) && (funct == 2'b00);
    is_ndz     = (opcode == OpNand) && (funct == 2'b01);
    is_lw      = (opcode == OpLw);
    is_sw      = (opcode == OpSw);
    is_beq     = (opcode == OpBeq);
    is_jal     = (opcode == OpJal);
    is_alu_grp = is_add | is_adc | is_ndu | is_ndz;
    is_legal   = is_alu_grp | is_lw | is_sw | is_beq | is_jal;
    // Conditional forms retire silently when their flag is clear.
    wb_write_en = is_add | is_ndu | is_lw | (is_adc & flag_c_q) | (is_ndz & flag_z_q);
  end

  always_comb begin
    alu_ctrl = AluAdd;
    if (is_ndu || is_ndz) begin
      alu_ctrl = AluNand;
    end else if (is_beq) begin
      alu_ctrl = AluSub;
    end else if (is_jal || !is_legal) begin
      alu_ctrl = AluPass;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign imm_sext = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign op_b     = (is_lw || is_sw) ? imm_sext : rd2;
  assign sum      = {1'b0, rd1} + {1'b0, op_b};

  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    unique case (alu_ctrl)
      AluAdd: begin
        alu_out   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      AluNand: alu_out = ~(rd1 & op_b);
      AluSub:  alu_out = rd1 - op_b;
      AluPass: alu_out = rd1;
    endcase
  end

  assign alu_zero = (alu_out == '0);
  assign mem_addr = alu_out[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Control FSM (Moore strobes)
  // ---------------------------------------------------------------------------
`ifdef RISC24_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d, illegal_set;
`endif

  always_comb begin
    state_d   = state_q;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    wb_sel    = WbAlu;
`ifdef RISC24_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        state_d = StExec;
`ifdef RISC24_ILLEGAL_TRAP_EN
        if (!is_legal) begin
          state_d     = StHalt;
          illegal_set = 1'b1;
        end
`endif
      end
      StExec: begin
        if (is_alu_grp) begin
          state_d = StWb;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          // BEQ, JAL and undefined-as-NOP all retire here.
          state_d  = StFetch;
          pc_write = 1'b1;
          branch   = is_beq & alu_zero;
          if (is_jal) begin
            jal       = 1'b1;
            reg_write = 1'b1;
            wb_sel    = WbPc;
          end
        end
      end
      StMem: begin
        if (is_lw) begin
          mem_read = 1'b1;
          state_d  = StWb;
        end else begin
          mem_write = is_sw;
          pc_write  = 1'b1;
          state_d   = StFetch;
        end
      end
      StWb: begin
        reg_write = wb_write_en;
        pc_write  = 1'b1;
        wb_sel    = is_lw ? WbMem : WbAlu;
        state_d   = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Architectural state next-values
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_d      = (state_q == StFetch) ? instr : ir_q;
    mem_out_d = mem_read ? mem_q[mem_addr] : mem_out_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    // Flags follow the register write, so suppressed ADC/NDZ leave them alone.
    if ((state_q == StWb) && is_alu_grp && reg_write) begin
      flag_z_d = alu_zero;
      if (is_add || is_adc) begin
        flag_c_d = alu_carry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      mem_out_q <= mem_out_d;
    end
  end

  // Array is deliberately unreset; a reset in MEM clears the strobe before the edge.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem_q[mem_addr] <= sw_data;
    end
  end

`ifdef RISC24_ILLEGAL_TRAP_EN
  assign illegal_d = illegal_q | illegal_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign mem_out = mem_out_q;

endmodule

// File: tb/tb_risc24_exec_core.sv
// Scoreboard bench for risc24_exec_core: stimulus queues expected retire records,
// a monitor pops and checks them on every pc_write pulse.
module tb_risc24_exec_core;

  logic        clk, reset;
  logic [15:0] instr, rd1, rd2, sw_data;
  logic [15:0] alu_out, mem_out;
  logic        alu_zero, alu_carry, flag_c, flag_z;
  logic [1:0]  alu_ctrl, wb_sel;
  logic        reg_write, mem_read, mem_write, pc_write, branch, jal, illegal;

  risc24_exec_core dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .rd1       (rd1),
    .rd2       (rd2),
    .sw_data   (sw_data),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .pc_write  (pc_write),
    .branch    (branch),
    .jal       (jal),
    .wb_sel    (wb_sel),
    .mem_out   (mem_out),
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    int          lat;
    bit          chk_alu;
    logic [15:0] alu;
    logic        rw, br, jl, mw;
    logic [1:0]  ws;
    bit          chk_mem;
    logic [15:0] mo;
    logic        fc, fz;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input int lat, input bit ca,
                              input logic [15:0] alu, input logic rw, br, jl, mw,
                              input logic [1:0] ws, input bit cm, input logic [15:0] mo,
                              input logic fc, fz);
    exp_t e;
    e.name = nm; e.lat = lat; e.chk_alu = ca; e.alu = alu;
    e.rw = rw; e.br = br; e.jl = jl; e.mw = mw; e.ws = ws;
    e.chk_mem = cm; e.mo = mo; e.fc = fc; e.fz = fz;
    return e;
  endfunction

  // Monitor: latency counted in cycles from FETCH, flags checked the cycle after retire.
  initial begin
    exp_t e;
    int   cyc = 0;
    bit   flag_pending = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        flag_pending = 0;
      end else begin
        if (flag_pending) begin
          chk({e.name, " flag_c"}, flag_c, e.fc);
          chk({e.name, " flag_z"}, flag_z, e.fz);
          flag_pending = 0;
        end
        cyc++;
        chk("stray strobe", (reg_write | branch | jal | mem_write) & ~pc_write, 0);
        if (pc_write) begin
          if (sb_q.size() == 0) begin
            chk("unexpected retire", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, " latency"}, cyc, e.lat);
            if (e.chk_alu) chk({e.name, " alu_out"}, alu_out, e.alu);
            chk({e.name, " reg_write"}, reg_write, e.rw);
            chk({e.name, " branch"}, branch, e.br);
            chk({e.name, " jal"}, jal, e.jl);
            chk({e.name, " mem_write"}, mem_write, e.mw);
            chk({e.name, " wb_sel"}, wb_sel, e.ws);
            if (e.chk_mem) chk({e.name, " mem_out"}, mem_out, e.mo);
            flag_pending = 1;
          end
          cyc = 0;
        end
      end
    end
  end

  // Drive one instruction from FETCH and return at the start of the next FETCH.
  task automatic issue(input logic [15:0] i, a, b, sd, input exp_t e);
    bit seen = 0;
    instr = i; rd1 = a; rd2 = b; sw_data = sd;
    sb_q.push_back(e);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pc_write) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({e.name, " retire timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " reg_write"}, reg_write, 0);
    chk({tag, " mem_read"}, mem_read, 0);
    chk({tag, " mem_write"}, mem_write, 0);
    chk({tag, " pc_write"}, pc_write, 0);
    chk({tag, " branch"}, branch, 0);
    chk({tag, " jal"}, jal, 0);
    chk({tag, " wb_sel"}, wb_sel, 0);
    chk({tag, " flag_c"}, flag_c, 0);
    chk({tag, " flag_z"}, flag_z, 0);
    chk({tag, " mem_out"}, mem_out, 0);
    chk({tag, " illegal"}, illegal, 0);
  endtask

  initial begin
    reset = 1'b1;
    instr = '0; rd1 = '0; rd2 = '0; sw_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // name lat chk_alu alu rw br jl mw ws chk_mem mo fc fz
    issue(16'h0000, 16'hFFFF, 16'h0001, 16'h0,
          mk("add wrap", 4, 1, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 0, 1, 1));
    issue(16'h0000, 16'h0001, 16'h0001, 16'h0,
          mk("add small", 4, 1, 16'h0002, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'h0002, 16'h0007, 16'h0008, 16'h0,
          mk("adc c0", 4, 1, 16'h000F, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'h0000, 16'h8000, 16'h8000, 16'h0,
          mk("add carry", 4, 1, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 0, 1, 1));
    issue(16'h0002, 16'h0002, 16'h0003, 16'h0,
          mk("adc c1", 4, 1, 16'h0005, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'h2000, 16'hFFFF, 16'hFFFF, 16'h0,
          mk("ndu", 4, 1, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    issue(16'h2001, 16'h00F0, 16'h0F00, 16'h0,
          mk("ndz z1", 4, 1, 16'hFFFF, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'h2001, 16'hFFFF, 16'hFFFF, 16'h0,
          mk("ndz z0", 4, 1, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'h9002, 16'h0010, 16'h0, 16'hBEEF,
          mk("sw 12", 4, 1, 16'h0012, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    issue(16'hA002, 16'h0010, 16'h0, 16'h0,
          mk("lw 12", 5, 1, 16'h0012, 1, 0, 0, 0, 2'b01, 1, 16'hBEEF, 0, 0));
    issue(16'h9003, 16'h0110, 16'h0, 16'hCAFE,
          mk("sw wrap", 4, 1, 16'h0113, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    issue(16'hA000, 16'h0013, 16'h0, 16'h0,
          mk("lw 13", 5, 1, 16'h0013, 1, 0, 0, 0, 2'b01, 1, 16'hCAFE, 0, 0));
    issue(16'hA03F, 16'h0014, 16'h0, 16'h0,
          mk("lw neg imm", 5, 1, 16'h0013, 1, 0, 0, 0, 2'b01, 1, 16'hCAFE, 0, 0));
    issue(16'hB005, 16'h1234, 16'h1234, 16'h0,
          mk("beq taken", 3, 1, 16'h0000, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'hB005, 16'h1234, 16'h1235, 16'h0,
          mk("beq not", 3, 1, 16'hFFFF, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'hD004, 16'h0040, 16'h0000, 16'h0,
          mk("jal", 3, 1, 16'h0040, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0));

    // Abort a SW while it sits in MEM; the stored word must survive.
    instr = 16'h9002; rd1 = 16'h0010; rd2 = 16'h0; sw_data = 16'h1111;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    @(posedge clk);
    #1 reset = 1'b0;
    issue(16'hA002, 16'h0010, 16'h0, 16'h0,
          mk("lw after abort", 5, 1, 16'h0012, 1, 0, 0, 0, 2'b01, 1, 16'hBEEF, 0, 0));

`ifdef RISC24_ILLEGAL_TRAP_EN
    begin
      int n_pw = 0;
      instr = 16'hF000; rd1 = '0; rd2 = '0;
      repeat (12) begin
        @(negedge clk);
        if (pc_write) n_pw++;
      end
      chk("halt illegal", illegal, 1);
      chk("halt retires", n_pw, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("halt reset illegal", illegal, 0);
      @(posedge clk);
      #1 reset = 1'b0;
    end
`else
    issue(16'h0001, 16'h0005, 16'h0006, 16'h0,
          mk("nop funct", 3, 0, 16'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    issue(16'hF000, 16'h0005, 16'h0006, 16'h0,
          mk("nop op f", 3, 0, 16'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    chk("illegal tied", illegal, 0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
